// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and S-box tables for the HEA round datapath.
package aes_pkg;

    localparam int unsigned STATE_BYTES = 16;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [0:0] {IDLE, RUN} isb_state_e;

    // Forward table, consumed by sub_bytes on the encrypt side.
    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sub_bytes_if.sv
// Start/result bundle between the InvShiftRows producer and the InvSubBytes stage.
interface inv_sub_bytes_if;
    import aes_pkg::*;

    aes_state_t b;
    logic       start;
    aes_state_t b_isb;
    logic       busy;
    logic       done;

    modport master (output b, output start, input b_isb, input busy, input done);
    modport slave  (input b, input start, output b_isb, output busy, output done);

endinterface

// File: rtl/inv_sbox.sv
// Single-byte combinational inverse S-box lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t a_i,
    output aes_byte_t y_o
);

    assign y_o = INV_SBOX[a_i];

endmodule

// File: rtl/inv_sub_bytes.sv
// Iterative InvSubBytes: substitutes a captured state BYTES_PER_CYCLE bytes per clock.
module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int unsigned BYTES_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rst_n,
    inv_sub_bytes_if.slave   bus
);

    localparam int unsigned NBEATS = (BYTES_PER_CYCLE == 0) ? 1 : STATE_BYTES / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W  = $clog2(NBEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    if (BYTES_PER_CYCLE == 0 || (STATE_BYTES % BYTES_PER_CYCLE) != 0) begin : g_bad_bpc
        $error("inv_sub_bytes: BYTES_PER_CYCLE must divide 16");
    end

    isb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aes_state_t       s_q, s_d;
    aes_state_t       b_isb_q, b_isb_d;
    logic             done_q, done_d;

    aes_byte_t sel [BYTES_PER_CYCLE];
    aes_byte_t sub [BYTES_PER_CYCLE];

    // Byte 0 lives in the MSBs, so beat n covers bytes n*BPC .. n*BPC+BPC-1 from the top.
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sel[j] = '0;
        end
        for (int n = 0; n < NBEATS; n++) begin
            if (cnt_q == CNT_W'(n)) begin
                for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                    sel[j] = s_q[127 - 8 * (n * BYTES_PER_CYCLE + j) -: 8];
                end
            end
        end
    end

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .a_i (sel[j]),
            .y_o (sub[j])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        b_isb_d = b_isb_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    s_d     = bus.b;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                for (int n = 0; n < NBEATS; n++) begin
                    if (cnt_q == CNT_W'(n)) begin
                        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
                            b_isb_d[127 - 8 * (n * BYTES_PER_CYCLE + j) -: 8] = sub[j];
                        end
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BEAT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            b_isb_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            b_isb_q <= b_isb_d;
            done_q  <= done_d;
        end
    end

    assign bus.b_isb = b_isb_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Randomised bench for inv_sub_bytes at BPC 1, 4 and 16 against a GF(2^8)-derived S-box model.
module tb_inv_sub_bytes;
    import aes_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inv_sub_bytes_if if1 ();
    inv_sub_bytes_if if4 ();
    inv_sub_bytes_if if16 ();

    inv_sub_bytes #(.BYTES_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    inv_sub_bytes #(.BYTES_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    inv_sub_bytes #(.BYTES_PER_CYCLE(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] sbox_m  [256];
    logic [7:0] isbox_m [256];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic aes_state_t ref_inv(input aes_state_t s);
        aes_state_t r;
        for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = isbox_m[s[127 - 8 * k -: 8]];
        return r;
    endfunction

    function automatic aes_state_t ref_fwd(input aes_state_t s);
        aes_state_t r;
        for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = sbox_m[s[127 - 8 * k -: 8]];
        return r;
    endfunction

    function automatic aes_state_t rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input int w, input aes_state_t d, input logic st);
        case (w)
            1:  begin if1.b  = d; if1.start  = st; end
            4:  begin if4.b  = d; if4.start  = st; end
            16: begin if16.b = d; if16.start = st; end
            default: ;
        endcase
    endtask

    function automatic logic get_done(input int w);
        return (w == 1) ? if1.done : (w == 4) ? if4.done : if16.done;
    endfunction

    function automatic aes_state_t get_out(input int w);
        return (w == 1) ? if1.b_isb : (w == 4) ? if4.b_isb : if16.b_isb;
    endfunction

    // Issues a one-cycle start and counts edges after the start edge until done.
    task automatic run_op(input int w, input aes_state_t d, output aes_state_t q, output int lat);
        @(posedge clk); #1;
        drive(w, d, 1'b1);
        @(posedge clk); #1;
        drive(w, rnd_state(), 1'b0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (get_done(w)) begin
                lat = i;
                break;
            end
        end
        q = get_out(w);
    endtask

    initial begin
        aes_state_t q, d1, d2, d3, d4, qref;
        aes_state_t pats [4];
        int         ws [3];
        int         lat, early, seen, changes, busy_seen;
        logic [7:0] iv, sv;

        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            end
            sv = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
            sbox_m[x]  = sv;
            isbox_m[sv] = 8'(x);
        end

        drive(1, '0, 1'b0);
        drive(4, '0, 1'b0);
        drive(16, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_b_isb1", if1.b_isb, '0);
        check_eq("rst_busy1", 128'(if1.busy), '0);
        check_eq("rst_done1", 128'(if1.done), '0);
        check_eq("rst_b_isb16", if16.b_isb, '0);
        rst_n = 1'b1;

        run_op(1, 128'h638293c31bfc33f5c4eeacea4bc12816, q, lat);
        check_eq("kv_lat", 128'(lat), 128'(16));
        check_eq("kv_data", q, 128'h00112233445566778899aabbccddeeff);

        ws   = '{1, 4, 16};
        pats = '{128'h0, {16{8'h63}}, {16{8'h7c}}, {16{8'h16}}};
        for (int wi = 0; wi < 3; wi++) begin
            for (int p = 0; p < 4; p++) begin
                run_op(ws[wi], pats[p], q, lat);
                check_eq($sformatf("corner_lat_w%0d_p%0d", ws[wi], p), 128'(lat), 128'(16 / ws[wi]));
                check_eq($sformatf("corner_data_w%0d_p%0d", ws[wi], p), q, ref_inv(pats[p]));
            end
        end

        for (int i = 0; i < 200; i++) begin
            d1 = rnd_state();
            run_op(ws[i % 3], ref_fwd(d1), q, lat);
            check_eq($sformatf("rt_%0d_w%0d", i, ws[i % 3]), q, d1);
        end

        // Mid-run start and input churn must not disturb the captured state.
        d1 = rnd_state();
        d2 = rnd_state();
        @(posedge clk); #1;
        drive(1, d1, 1'b1);
        @(posedge clk); #1;
        drive(1, rnd_state(), 1'b0);
        early = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 3) drive(1, rnd_state(), 1'b1);
            if (i == 4) drive(1, rnd_state(), 1'b0);
            if (i < 16 && if1.done) early++;
        end
        check_eq("hs_done", 128'(if1.done), 128'(1));
        check_eq("hs_busy_fall", 128'(if1.busy), '0);
        check_eq("hs_data", if1.b_isb, ref_inv(d1));
        check_eq("hs_early_done", 128'(early), '0);
        drive(1, d2, 1'b1);
        @(posedge clk); #1;
        drive(1, rnd_state(), 1'b0);
        check_eq("hs_done_clear", 128'(if1.done), '0);
        check_eq("hs_busy_again", 128'(if1.busy), 128'(1));
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (if1.done) begin
                lat = i;
                break;
            end
        end
        check_eq("hs_b2b_lat", 128'(lat), 128'(16));
        check_eq("hs_b2b_data", if1.b_isb, ref_inv(d2));
        @(posedge clk); #1;
        check_eq("hs_single_pulse", 128'(if1.done), '0);

        d3 = rnd_state();
        @(posedge clk); #1;
        drive(1, d3, 1'b1);
        @(posedge clk); #1;
        drive(1, d3, 1'b0);
        repeat (7) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check_eq("arst_b_isb", if1.b_isb, '0);
        check_eq("arst_busy", 128'(if1.busy), '0);
        check_eq("arst_done", 128'(if1.done), '0);
        #20;
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (if1.done) seen++;
        end
        check_eq("arst_no_done", 128'(seen), '0);

        d4 = rnd_state();
        run_op(1, d4, q, lat);
        check_eq("post_rst_lat", 128'(lat), 128'(16));
        check_eq("post_rst_data", q, ref_inv(d4));

        qref      = ref_inv(d4);
        changes   = 0;
        busy_seen = 0;
        repeat (50) begin
            @(posedge clk); #1;
            drive(1, rnd_state(), 1'b0);
            if (if1.b_isb !== qref) changes++;
            if (if1.busy) busy_seen++;
        end
        check_eq("idle_hold_changes", 128'(changes), '0);
        check_eq("idle_hold_busy", 128'(busy_seen), '0);
        check_eq("idle_hold_data", if1.b_isb, qref);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
